dds_seq_ctrl: RTL and testbench
===============================

Name: dds_seq_ctrl

Overview:
- Configuration sequencer for the AD9833-class DDS on the scope board.
- Accepts frequency, phase and waveform settings from the PicoBlaze port bus, then autonomously emits the 5-word serial program (reset, FREQ0 LSB, FREQ0 MSB, PHASE0, run) on FSYNC/SCLK/SDATA.
- Reports busy, pending and done status back to the PicoBlaze. Firmware no longer bit-bangs or sequences individual words.

Parameters:
- BASE, 0: first port_id of the 8-address register window (BASE+0..BASE+7).
- CLK_DIV, 2: SCLK half-period in clk cycles; legal range 1..255.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- port_id  input  8  PicoBlaze port address.
- out_port  input  8  PicoBlaze write data.
- write_strobe  input  1  one-clk write pulse, sampled on posedge clk.
- in_port  output  8  status byte; valid while port_id==BASE+7, 0 otherwise.
- FSYNC  output  1  DDS frame sync, active low.
- SCLK  output  1  DDS serial clock, idles high.
- SDATA  output  1  DDS serial data, MSB first.

Behaviour:
- Reset is asynchronous and active-low; clk is the single clock.
- Reset values: FSYNC=1, SCLK=1, SDATA=0, in_port=0, all registers, shadows, pending flag and done counter 0, state IDLE.
- Reset asserted mid-frame aborts immediately with the same values; no partial word is completed.
- Host writes (write_strobe=1 and port_id matches):
  - BASE+0..3: freq[7:0], [15:8], [23:16], [27:24]. Upper nibble of BASE+3 is ignored.
  - BASE+4..5: phase[7:0], phase[11:8]. Upper nibble of BASE+5 is ignored.
  - BASE+6: commit. out_port[1:0]=mode, out_port[3:2]=sleep bits.
  - Other offsets: no effect.
- Mode to control-word bits: 0 sine 0x0000, 1 triangle 0x0002, 2 square 0x0028, 3 square/2 0x0020.
- Commit in IDLE: on the following clk, freq/phase/mode are copied into shadow registers, busy=1 and state goes to LOAD. Host registers may be rewritten freely while busy.
- Commit while busy: sets pending=1; the running sequence is not disturbed. On DONE with pending=1, clear pending, re-latch shadows and restart at word 0. Multiple commits while busy collapse into one pending.
- Word list, built from shadows:
  - W0 = 0x2100|mode (B28, RESET).
  - W1 = 0x4000|freq[13:0].
  - W2 = 0x4000|freq[27:14].
  - W3 = 0xC000|phase[11:0].
  - W4 = 0x2000|mode|sleep.
- FSM states: IDLE, LOAD, SETUP, SHIFT, GAP, DONE.
  - LOAD: select W[idx], load the 16-bit shifter, FSYNC goes 0.
  - SETUP: CLK_DIV cycles with SCLK=1 and SDATA=bit15.
  - SHIFT: per bit, CLK_DIV cycles SCLK=0 then CLK_DIV cycles SCLK=1. SDATA changes only at the start of the SCLK-high phase, so it is stable across the falling edge. After bit 0's high phase, FSYNC=1.
  - GAP: 2*CLK_DIV cycles with FSYNC=1, SCLK=1. Then idx+1 goes to LOAD, or idx==4 goes to DONE.
  - DONE: one cycle; increments the done counter (4-bit, wraps 15 to 0). Goes to IDLE (busy=0) or restarts if pending.
- Timing per word: CLK_DIV + 32*CLK_DIV + 2*CLK_DIV cycles plus 1 LOAD cycle. CLK_DIV=2 gives 71 per word; the full sequence is 355 + DONE = 356 cycles from LOAD to IDLE.
- Exactly 16 SCLK falling edges occur while FSYNC=0 per word; none occur while FSYNC=1.
- SDATA=0 whenever FSYNC=1.
- Status at BASE+7: bit0 busy, bit1 pending, bits3:2 0, bits7:4 done count. The read has no side effects.

Optional Feature:
- DDS_SLEEP_EN defined: the sleep bits from the commit map to W4 bit7 (SLEEP1) and bit6 (SLEEP12).
- DDS_SLEEP_EN undefined: W4 bits 7:6 are forced 0 and out_port[3:2] is ignored.

Test Plan:
- Reset: hold rst_n=0, then release. Required: FSYNC=1, SCLK=1, SDATA=0, in_port(BASE+7)=0x00, no SCLK activity for 1000 cycles.
- Single program: freq=0x0ABCDEF, phase=0x123, commit mode=1, CLK_DIV=2.
  - Decoded words: 0x2102, 0x4DEF (freq[13:0]=0x0DEF), 0x42AF (freq[27:14]=0x2AF), 0xC123, 0x2002.
  - Busy high for exactly 356 cycles; done count then reads 1 (in_port=0x10).
- Commit while busy: second commit with freq=0x0000001 at word 2. Required:
  - Pending=1 (in_port bit1) until the first sequence ends.
  - Second sequence sends W1=0x4001, W2=0x4000.
  - Done count 2, 10 words total, no gap in busy.
- Host rewrite during busy: write BASE+0=0xFF mid-W1. Required: the running sequence still sends the originally latched values.
- Async reset mid-SHIFT in W2: FSYNC, SCLK and state return immediately to reset values. A later commit runs a clean 5-word sequence.
- Macro check: commit 0x0E (mode 2, sleep 3). With DDS_SLEEP_EN, W4=0x20E8; without it, W4=0x2028.

Source files
------------

// File: rtl/dds_seq_ctrl_if.sv
// PicoBlaze port bus as seen by the DDS sequencer: write address/data/strobe
// from the processor, status byte back to it.
interface dds_seq_ctrl_if;
    logic [7:0] port_id;
    logic [7:0] out_port;
    logic       write_strobe;
    logic [7:0] in_port;

    modport master (
        output port_id,
        output out_port,
        output write_strobe,
        input  in_port
    );

    modport slave (
        input  port_id,
        input  out_port,
        input  write_strobe,
        output in_port
    );
endinterface

// File: rtl/dds_seq_ctrl.sv
// AD9833-class DDS configuration sequencer.
// Host writes freq/phase/mode through an 8-address port window, a commit
// latches them into shadows and the FSM streams the 5-word program
// (reset, FREQ0 LSB, FREQ0 MSB, PHASE0, run) out on FSYNC/SCLK/SDATA.
// Optional build macro: DDS_SLEEP_EN -- routes commit sleep bits into
// the run word (bit7 SLEEP1, bit6 SLEEP12); otherwise they are forced 0.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a commit, serial lines idle
// LOAD  | pick word[idx] into the shifter, FSYNC drops
// SETUP | CLK_DIV cycles SCLK high with bit15 presented on SDATA
// SHIFT | 16 bits, each CLK_DIV low then CLK_DIV high; DDS samples on fall
// GAP   | 2*CLK_DIV cycles FSYNC high between words
// DONE  | bump done counter, restart if a commit is pending
module dds_seq_ctrl #(
    parameter logic [7:0] BASE    = 8'h00,
    parameter int         CLK_DIV = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    dds_seq_ctrl_if.slave  bus,
    output logic           FSYNC,
    output logic           SCLK,
    output logic           SDATA
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SETUP = 3'd2,
        SHIFT = 3'd3,
        GAP   = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [8:0] DIV_M1 = 9'(CLK_DIV - 1);
    localparam logic [8:0] GAP_M1 = 9'(2 * CLK_DIV - 1);

    state_t      state, state_nxt;
    logic [8:0]  cnt, cnt_nxt;
    logic [2:0]  idx, idx_nxt;
    logic [3:0]  bitn, bitn_nxt;
    logic        half, half_nxt;
    logic [15:0] shreg, shreg_nxt;
    logic        latch;

    logic [27:0] freq_reg, sh_freq;
    logic [11:0] phase_reg, sh_phase;
    logic [1:0]  mode_reg, sh_mode, mode_src;
    logic [1:0]  sleep_reg, sh_sleep, sleep_src, sleep_in;
    logic        pending;
    logic [3:0]  done_cnt;
    logic        busy;

    logic [7:0]  offset;
    logic        hit, wr, commit;
    logic [15:0] ctrl_bits, word;

    // The window may sit anywhere in port space, so decode by offset.
    assign offset = bus.port_id - BASE;
    assign hit    = (offset[7:3] == 5'd0);
    assign wr     = bus.write_strobe & hit;
    assign commit = wr && (offset[2:0] == 3'd6);
    assign busy   = (state != IDLE);

`ifdef DDS_SLEEP_EN
    assign sleep_in = bus.out_port[3:2];
`else
    assign sleep_in = 2'b00;
`endif

    // A commit that starts a sequence in the same cycle has not reached
    // mode_reg yet, so take mode/sleep straight from the bus.
    assign mode_src  = commit ? bus.out_port[1:0] : mode_reg;
    assign sleep_src = commit ? sleep_in : sleep_reg;

    // Host-visible configuration registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            freq_reg  <= '0;
            phase_reg <= '0;
            mode_reg  <= '0;
            sleep_reg <= '0;
        end else if (wr) begin
            case (offset[2:0])
                3'd0: freq_reg[7:0]   <= bus.out_port;
                3'd1: freq_reg[15:8]  <= bus.out_port;
                3'd2: freq_reg[23:16] <= bus.out_port;
                3'd3: freq_reg[27:24] <= bus.out_port[3:0];
                3'd4: phase_reg[7:0]  <= bus.out_port;
                3'd5: phase_reg[11:8] <= bus.out_port[3:0];
                3'd6: begin
                    mode_reg  <= bus.out_port[1:0];
                    sleep_reg <= sleep_in;
                end
                default: ;
            endcase
        end
    end

    // Shadows freeze the settings for the sequence in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_freq  <= '0;
            sh_phase <= '0;
            sh_mode  <= '0;
            sh_sleep <= '0;
        end else if (latch) begin
            sh_freq  <= freq_reg;
            sh_phase <= phase_reg;
            sh_mode  <= mode_src;
            sh_sleep <= sleep_src;
        end
    end

    // Pending flag collapses any number of commits during a run; done counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending  <= 1'b0;
            done_cnt <= 4'd0;
        end else if (state == DONE) begin
            pending  <= 1'b0;
            done_cnt <= done_cnt + 4'd1;
        end else if (commit && busy) begin
            pending  <= 1'b1;
        end
    end

    // Word table built from the shadows.
    always_comb begin
        ctrl_bits = 16'h0000;
        case (sh_mode)
            2'd0: ctrl_bits = 16'h0000;
            2'd1: ctrl_bits = 16'h0002;
            2'd2: ctrl_bits = 16'h0028;
            default: ctrl_bits = 16'h0020;
        endcase
        word = 16'h0000;
        case (idx)
            3'd0: word = 16'h2100 | ctrl_bits;
            3'd1: word = {2'b01, sh_freq[13:0]};
            3'd2: word = {2'b01, sh_freq[27:14]};
            3'd3: word = {4'hC, sh_phase};
            default: word = 16'h2000 | ctrl_bits | {8'h00, sh_sleep, 6'h00};
        endcase
    end

    // FSM and serial datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            bitn  <= '0;
            half  <= 1'b0;
            shreg <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
            bitn  <= bitn_nxt;
            half  <= half_nxt;
            shreg <= shreg_nxt;
        end
    end

    // Next-state logic; timers are down-counters ending at zero.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        bitn_nxt  = bitn;
        half_nxt  = half;
        shreg_nxt = shreg;
        latch     = 1'b0;
        case (state)
            IDLE: begin
                if (commit) begin
                    state_nxt = LOAD;
                    idx_nxt   = 3'd0;
                    latch     = 1'b1;
                end
            end
            LOAD: begin
                shreg_nxt = word;
                cnt_nxt   = DIV_M1;
                state_nxt = SETUP;
            end
            SETUP: begin
                if (cnt != 9'd0) begin
                    cnt_nxt = cnt - 9'd1;
                end else begin
                    state_nxt = SHIFT;
                    half_nxt  = 1'b0;
                    bitn_nxt  = 4'd15;
                    cnt_nxt   = DIV_M1;
                end
            end
            SHIFT: begin
                if (cnt != 9'd0) begin
                    cnt_nxt = cnt - 9'd1;
                end else if (!half) begin
                    // SDATA moves only as SCLK rises, never near the falling edge.
                    half_nxt  = 1'b1;
                    cnt_nxt   = DIV_M1;
                    shreg_nxt = {shreg[14:0], 1'b0};
                end else if (bitn == 4'd0) begin
                    state_nxt = GAP;
                    cnt_nxt   = GAP_M1;
                end else begin
                    bitn_nxt = bitn - 4'd1;
                    half_nxt = 1'b0;
                    cnt_nxt  = DIV_M1;
                end
            end
            GAP: begin
                if (cnt != 9'd0) begin
                    cnt_nxt = cnt - 9'd1;
                end else if (idx == 3'd4) begin
                    state_nxt = DONE;
                end else begin
                    idx_nxt   = idx + 3'd1;
                    state_nxt = LOAD;
                end
            end
            DONE: begin
                if (pending || commit) begin
                    state_nxt = LOAD;
                    idx_nxt   = 3'd0;
                    latch     = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Serial pins and status byte decoded from registered state.
    always_comb begin
        FSYNC  = !((state == LOAD) || (state == SETUP) || (state == SHIFT));
        SCLK   = !((state == SHIFT) && !half);
        SDATA  = ((state == SETUP) || (state == SHIFT)) && shreg[15];
        bus.in_port = (offset == 8'd7) ? {done_cnt, 2'b00, pending, busy} : 8'h00;
    end

endmodule

// File: tb/tb_dds_seq_ctrl.sv
// Directed bench for dds_seq_ctrl: a vector table of programs plus
// hand-written sequences for pending commits, rewrites and mid-frame reset.
module tb_dds_seq_ctrl;

    localparam logic [7:0] BASE = 8'h40;
    localparam logic [7:0] STAT = 8'h47;

    logic clk = 1'b0;
    logic rst_n;
    logic FSYNC, SCLK, SDATA;

    dds_seq_ctrl_if bus ();

    dds_seq_ctrl #(.BASE(BASE), .CLK_DIV(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .FSYNC (FSYNC),
        .SCLK  (SCLK),
        .SDATA (SDATA)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Serial receiver: captures words on SCLK falling edges while FSYNC is low.
    logic [15:0] mon_sh = 16'h0;
    int          mon_bits = 0;
    logic [15:0] words[$];
    int          sclk_falls = 0;
    int          idle_err = 0;
    int          frame_err = 0;

    always @(negedge SCLK) begin
        sclk_falls++;
        if (FSYNC) idle_err++;
        else begin
            mon_sh = {mon_sh[14:0], SDATA};
            mon_bits++;
            if (mon_bits == 16) words.push_back(mon_sh);
        end
    end

    always @(negedge FSYNC) mon_bits = 0;

    always @(posedge FSYNC) if (rst_n === 1'b1 && mon_bits != 16) frame_err++;

    always @(negedge clk) if (FSYNC === 1'b1 && SDATA !== 1'b0) idle_err++;

    int commit_cyc;

    task automatic host_write(input logic [7:0] off, input logic [7:0] d);
        bus.port_id      = BASE + off;
        bus.out_port     = d;
        bus.write_strobe = 1'b1;
        @(posedge clk);
        #1;
        bus.write_strobe = 1'b0;
        bus.port_id      = STAT;
        bus.out_port     = 8'h00;
    endtask

    task automatic program_regs(input logic [27:0] f, input logic [11:0] p);
        host_write(8'd0, f[7:0]);
        host_write(8'd1, f[15:8]);
        host_write(8'd2, f[23:16]);
        host_write(8'd3, {4'hA, f[27:24]});
        host_write(8'd4, p[7:0]);
        host_write(8'd5, {4'h5, p[11:8]});
    endtask

    task automatic do_commit(input logic [7:0] cmd);
        host_write(8'd6, cmd);
        commit_cyc = cyc;
    endtask

    task automatic wait_idle(input int budget, output int cyc_end);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.in_port[0] && n < budget);
        cyc_end = cyc;
        check("idle_timeout", {31'd0, bus.in_port[0]}, 32'd0);
    endtask

    task automatic wait_words(input int n, input int budget);
        int k = 0;
        while (words.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("words_timeout", {31'd0, (words.size() >= n)}, 32'd1);
    endtask

    typedef struct packed {
        logic [27:0]      freq;
        logic [11:0]      phase;
        logic [7:0]       cmd;
        logic [4:0][15:0] w;
    } vec_t;

    vec_t       vecs[4];
    logic [3:0] exp_done = 4'd0;
    int         cend;
    logic [15:0] w4_sleep;

    initial begin
        rst_n            = 1'b0;
        bus.port_id      = STAT;
        bus.out_port     = 8'h00;
        bus.write_strobe = 1'b0;

`ifdef DDS_SLEEP_EN
        w4_sleep = 16'h20E8;
`else
        w4_sleep = 16'h2028;
`endif
        vecs[0] = '{freq: 28'h0ABCDEF, phase: 12'h123, cmd: 8'h01,
                    w: {16'h2002, 16'hC123, 16'h42AF, 16'h4DEF, 16'h2102}};
        vecs[1] = '{freq: 28'hFFFFFFF, phase: 12'hFFF, cmd: 8'h00,
                    w: {16'h2000, 16'hCFFF, 16'h7FFF, 16'h7FFF, 16'h2100}};
        vecs[2] = '{freq: 28'h0000001, phase: 12'h000, cmd: 8'h03,
                    w: {16'h2020, 16'hC000, 16'h4000, 16'h4001, 16'h2120}};
        vecs[3] = '{freq: 28'h1234567, phase: 12'h800, cmd: 8'h0E,
                    w: {w4_sleep, 16'hC800, 16'h448D, 16'h4567, 16'h2128}};

        // Reset values
        repeat (5) @(posedge clk);
        #1;
        check("rst_fsync", {31'd0, FSYNC}, 32'd1);
        check("rst_sclk",  {31'd0, SCLK},  32'd1);
        check("rst_sdata", {31'd0, SDATA}, 32'd0);
        check("rst_status", {24'd0, bus.in_port}, 32'h00);
        rst_n = 1'b1;
        begin
            int f0;
            f0 = sclk_falls;
            repeat (1000) @(posedge clk);
            #1;
            check("idle_sclk_quiet", sclk_falls - f0, 0);
            check("idle_fsync", {31'd0, FSYNC}, 32'd1);
        end

        // Writes outside the commit offset or the window must not start anything
        host_write(8'd7, 8'hFF);
        host_write(8'd8, 8'h06);
        host_write(8'hFF, 8'h06);
        repeat (5) @(posedge clk);
        #1;
        check("stray_write_status", {24'd0, bus.in_port}, 32'h00);
        check("stray_write_fsync", {31'd0, FSYNC}, 32'd1);

        // Vector table
        for (int v = 0; v < 4; v++) begin
            words.delete();
            program_regs(vecs[v].freq, vecs[v].phase);
            do_commit(vecs[v].cmd);
            wait_idle(1000, cend);
            check($sformatf("v%0d_busy_len", v), cend - commit_cyc, 356);
            check($sformatf("v%0d_nwords", v), words.size(), 5);
            for (int k = 0; k < 5; k++)
                check($sformatf("v%0d_w%0d", v, k), {16'd0, words[k]}, {16'd0, vecs[v].w[k]});
            exp_done++;
            check($sformatf("v%0d_status", v), {24'd0, bus.in_port}, {24'd0, exp_done, 4'h0});
        end

        // Status reads only at BASE+7
        bus.port_id = BASE + 8'd6;
        #1;
        check("status_other_addr", {24'd0, bus.in_port}, 32'h00);
        bus.port_id = STAT;
        #1;

        // Commit while busy, plus host rewrite during a run
        begin
            int first_c;
            words.delete();
            program_regs(28'h0ABCDEF, 12'h123);
            do_commit(8'h01);
            first_c = commit_cyc;
            wait_words(1, 400);
            repeat (12) @(posedge clk);
            #1;
            host_write(8'd0, 8'hFF);
            wait_words(2, 400);
            repeat (12) @(posedge clk);
            #1;
            host_write(8'd0, 8'h01);
            host_write(8'd1, 8'h00);
            host_write(8'd2, 8'h00);
            host_write(8'd3, 8'h00);
            do_commit(8'h01);
            @(negedge clk);
            check("pend_set", {30'd0, bus.in_port[1:0]}, 32'd3);
            wait_words(5, 400);
            @(negedge clk);
            check("pend_held", {30'd0, bus.in_port[1:0]}, 32'd3);
            wait_idle(2000, cend);
            check("pend_busy_len", cend - first_c, 712);
            check("pend_nwords", words.size(), 10);
            check("pend_a_w1", {16'd0, words[1]}, 32'h4DEF);
            check("pend_a_w2", {16'd0, words[2]}, 32'h42AF);
            check("pend_b_w0", {16'd0, words[5]}, 32'h2102);
            check("pend_b_w1", {16'd0, words[6]}, 32'h4001);
            check("pend_b_w2", {16'd0, words[7]}, 32'h4000);
            check("pend_b_w3", {16'd0, words[8]}, 32'hC123);
            check("pend_b_w4", {16'd0, words[9]}, 32'h2002);
            exp_done += 4'd2;
            check("pend_status", {24'd0, bus.in_port}, {24'd0, exp_done, 4'h0});
        end

        // Asynchronous reset in the middle of W2
        words.delete();
        program_regs(28'h0ABCDEF, 12'h123);
        do_commit(8'h01);
        wait_words(2, 400);
        repeat (20) @(posedge clk);
        #1;
        check("midw2_fsync_low", {31'd0, FSYNC}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("abort_fsync", {31'd0, FSYNC}, 32'd1);
        check("abort_sclk",  {31'd0, SCLK},  32'd1);
        check("abort_sdata", {31'd0, SDATA}, 32'd0);
        check("abort_status", {24'd0, bus.in_port}, 32'h00);
        check("abort_nwords", words.size(), 2);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_done = 4'd0;
        words.delete();
        program_regs(28'h0ABCDEF, 12'h123);
        do_commit(8'h01);
        wait_idle(1000, cend);
        check("post_rst_busy_len", cend - commit_cyc, 356);
        check("post_rst_nwords", words.size(), 5);
        for (int k = 0; k < 5; k++)
            check($sformatf("post_rst_w%0d", k), {16'd0, words[k]}, {16'd0, vecs[0].w[k]});
        exp_done++;
        check("post_rst_status", {24'd0, bus.in_port}, 32'h10);

        // Done counter wraps 15 -> 0
        for (int r = 0; r < 15; r++) begin
            do_commit(8'h00);
            wait_idle(1000, cend);
            exp_done++;
            check($sformatf("wrap_status_%0d", r), {24'd0, bus.in_port}, {24'd0, exp_done, 4'h0});
        end

        check("frame_errors", frame_err, 0);
        check("idle_line_errors", idle_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
